// File: rtl/reg_writeback_queue.sv
// In-order write-back queue feeding the register-file write port.
// It also offers a youngest-match forwarding lookup over the pending entries.
module reg_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_W-1:0]            in_addr,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         hold,
    output logic                         write_enable,
    output logic [ADDR_W-1:0]            write_addr,
    output logic [DATA_W-1:0]            write_data,
    input  logic [ADDR_W-1:0]            query_addr,
    output logic                         query_hit,
    output logic [DATA_W-1:0]            query_data,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop;

    assign in_ready     = (count_q < DEPTH_C);
    assign empty        = (count_q == '0);
    assign count        = count_q;
    assign write_enable = !empty && !hold;
    assign write_addr   = write_enable ? addr_q[rd_ptr_q] : '0;
    assign write_data   = write_enable ? data_q[rd_ptr_q] : '0;

    // x0 writes complete the handshake but never occupy an entry
    assign push = in_valid && in_ready && (in_addr != '0);
    assign pop  = write_enable;

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        vld_d    = vld_q;
        if (pop)
            vld_d[rd_ptr_q] = 1'b0;
        if (push)
            vld_d[wr_ptr_q] = 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            addr_q[wr_ptr_q] <= in_addr;
            data_q[wr_ptr_q] <= in_data;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest one
    always_comb begin
        query_hit  = 1'b0;
        query_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (vld_q[rd_ptr_q + PTR_W'(k)] && (addr_q[rd_ptr_q + PTR_W'(k)] == query_addr)
                && (query_addr != '0)) begin
                query_hit  = 1'b1;
                query_data = data_q[rd_ptr_q + PTR_W'(k)];
            end
        end
    end

endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Write-side initiator for the 32x32 register file. It drives the write_addr / write_data / write_enable port.
- Accepts results from execute over a valid/ready handshake and buffers them in a small in-order FIFO.
- Retires at most one entry per cycle into the register file.
- Offers a youngest-match forwarding lookup so decode can read values that have not yet been written.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  result offered by execute
- in_ready  output  1  queue can accept this cycle
- in_addr  input  ADDR_W  destination register
- in_data  input  DATA_W  result value
- hold  input  1  freeze retirement (pipeline stall); pushes are still allowed
- write_enable  output  1  register-file write strobe
- write_addr  output  ADDR_W  register-file write address
- write_data  output  DATA_W  register-file write data
- query_addr  input  ADDR_W  forwarding lookup address
- query_hit  output  1  a pending entry targets query_addr
- query_data  output  DATA_W  value of the youngest pending entry targeting query_addr
- count  output  clog2(DEPTH)+1  number of occupied entries
- empty  output  1  count == 0

Behaviour:
- Reset, synchronous, while rst=1 at a clock edge:
  - rd_ptr = wr_ptr = 0; count = 0; all entry valid bits cleared.
  - Outputs after reset: write_enable=0, write_addr=0, write_data=0, query_hit=0, query_data=0, empty=1, in_ready=1.
  - Entries are not written during reset. A push presented in the reset cycle is discarded.
- in_ready = (count < DEPTH), combinational from registered count. It never depends on in_valid.
- Push: occurs when in_valid && in_ready && in_addr != 0. The entry is written at wr_ptr; wr_ptr increments modulo DEPTH.
- Address 0: in_valid && in_ready && in_addr == 0 completes the handshake but enqueues nothing. count is unchanged. x0 is never written.
- Write port:
  - write_enable = !empty && !hold.
  - write_addr / write_data = head entry fields when write_enable=1, otherwise 0.
  - All three are combinational from queue registers only, with no path from in_*.
- Pop: occurs on any edge where write_enable=1. rd_ptr increments modulo DEPTH. The register file captures the write on that same edge.
- Latency:
  - A result pushed at edge N into an empty queue with hold=0 appears on the write port during cycle N..N+1.
  - It is retired at edge N+1.
  - It is visible in the register file from edge N+1.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- When full (count == DEPTH): in_ready=0, including in a cycle where a pop occurs. There is no pass-through.
- hold=1: nothing retires. Pushes continue until full. Deasserting hold resumes in FIFO order.
- Ordering: strictly in order. Two pending writes to the same register retire oldest first.
- Forwarding (combinational):
  - Scan all valid entries for addr == query_addr.
  - query_hit=1 if any match and query_addr != 0.
  - query_data = data of the youngest match (closest to wr_ptr-1), otherwise 0.
  - The entry being retired in the current cycle still counts as pending.
  - The entry being pushed in the current cycle is not visible until the next cycle.
- Pointer width: clog2(DEPTH) bits with natural wrap. count is tracked separately. Full and empty are derived from count, never from pointer equality.
- Reset while full or mid-hold: all pending writes are dropped and none reach the register file.

Test Plan:
- Reset, then push (addr=5, data=0xDEADBEEF) with hold=0 → next cycle write_enable=1, write_addr=5, write_data=0xDEADBEEF; one cycle later empty=1 and write_enable=0.
- Push addr=0, data=0x1234 → in_ready=1 and the handshake completes, but count stays 0 and write_enable stays 0.
- hold=1, push addr 1,2,3,4 with data 0x11..0x44 → count=4, in_ready=0, and a fifth push is not accepted. Release hold → writes 1,2,3,4 retire in consecutive cycles and count falls to 0.
- Push addr=7 data=0xA, then addr=7 data=0xB, with hold=1 → query_addr=7 gives query_hit=1, query_data=0xB; query_addr=8 gives query_hit=0, query_data=0. Release hold → 0xA is written before 0xB.
- Steady stream of pushes every cycle with hold=0 → count stays at 1 after the first push. The pointers wrap past DEPTH-1 with no lost or duplicated writes across 10 entries, addr 1..10, data = addr*3.
- Fill with hold=1 to count=3, then assert rst for one cycle → count=0, empty=1, write_enable=0. After hold=0, no stale write appears.
